jtopl_lfo_gen: RTL and testbench

Generates the low-frequency modulation sources consumed downstream: the 3-bit vibrato step counter `vib_cnt`, which feeds the phase-modulation offset logic, and the tremolo (AM) attenuation level. Both are derived from a per-sample timer advanced once per sample slot. It sits in the timing/LFO section, alongside the slot counter, and drives the phase generator and the envelope/AM path.

---
 rtl/jtopl_lfo_gen.sv | 110 +++++++++++
 tb/tb_jtopl_lfo_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_lfo_gen.sv
`default_nettype none
// ============================================================================
// Module      : jtopl_lfo_gen
// Description : LFO source generator. A per-sample timer drives a 3-bit
//               vibrato step counter and a triangle-shaped tremolo position,
//               from which the AM attenuation level is derived.
// Revision    : 1.0 - initial release
// ============================================================================
module jtopl_lfo_gen #(
    parameter int TIMER_W    = 10,
    parameter int TREM_DIV_W = 6,
    parameter int TREM_HALF  = 105
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       zero,
    input  logic       am_dep,
    input  logic       lfo_rst,
    output logic [2:0] vib_cnt,
    output logic [4:0] trem,
    output logic       vib_stb,
    output logic       trem_stb
);

    localparam int                POS_W       = 8;
    localparam logic [POS_W-1:0]  C_POS_LAST  = POS_W'(2*TREM_HALF-1);
    localparam logic [POS_W-1:0]  C_POS_FULL  = POS_W'(2*TREM_HALF);
    localparam logic [POS_W-1:0]  C_POS_HALF  = POS_W'(TREM_HALF);
    localparam logic [TIMER_W-1:0] C_TIMER_ONE = TIMER_W'(1);

    logic [TIMER_W-1:0] timer_q,    timer_d;
    logic [POS_W-1:0]   trem_pos_q, trem_pos_d;
    logic [2:0]         vib_cnt_q,  vib_cnt_d;
    logic [4:0]         trem_q,     trem_d;
    logic               vib_stb_q,  vib_stb_d;
    logic               trem_stb_q, trem_stb_d;

    logic               w_trem_step;
    logic               w_vib_step;
    logic [POS_W-1:0]   w_tri;

    // Step conditions look at the timer value before it increments, so the
    // vibrato step always coincides with a tremolo step.
    assign w_trem_step = zero & (&timer_q[TREM_DIV_W-1:0]);
    assign w_vib_step  = zero & (&timer_q);

    // Fold the tremolo position into a triangle: rises 0..HALF, falls back.
    assign w_tri = (trem_pos_q < C_POS_HALF) ? trem_pos_q
                                             : (C_POS_FULL - trem_pos_q);

    // Next-state logic; this only takes effect on cen cycles.
    always_comb begin
        timer_d    = timer_q;
        trem_pos_d = trem_pos_q;
        vib_cnt_d  = vib_cnt_q;
        trem_d     = trem_q;
        vib_stb_d  = 1'b0;
        trem_stb_d = 1'b0;

        if (lfo_rst) begin
            timer_d    = '0;
            trem_pos_d = '0;
            vib_cnt_d  = '0;
            trem_d     = '0;
        end else begin
            if (zero) begin
                timer_d = timer_q + C_TIMER_ONE;
            end
            if (w_trem_step) begin
                trem_pos_d = (trem_pos_q == C_POS_LAST) ? '0
                                                        : trem_pos_q + 8'd1;
                trem_stb_d = 1'b1;
            end
            if (w_vib_step) begin
                vib_cnt_d = vib_cnt_q + 3'd1;
                vib_stb_d = 1'b1;
            end
            // Attenuation follows the current position, hence it lags the
            // position step by one cen cycle; depth changes apply at once.
            trem_d = 5'(am_dep ? (w_tri >> 2) : (w_tri >> 4));
        end
    end

    // State registers: reset first, then hold unless cen is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q    <= '0;
            trem_pos_q <= '0;
            vib_cnt_q  <= '0;
            trem_q     <= '0;
            vib_stb_q  <= 1'b0;
            trem_stb_q <= 1'b0;
        end else if (cen) begin
            timer_q    <= timer_d;
            trem_pos_q <= trem_pos_d;
            vib_cnt_q  <= vib_cnt_d;
            trem_q     <= trem_d;
            vib_stb_q  <= vib_stb_d;
            trem_stb_q <= trem_stb_d;
        end
    end

    assign vib_cnt  = vib_cnt_q;
    assign trem     = trem_q;
    assign vib_stb  = vib_stb_q;
    assign trem_stb = trem_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_jtopl_lfo_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtopl_lfo_gen
// Description : Scoreboard bench for jtopl_lfo_gen. Stimulus pushes the
//               expected outputs for a given cycle; a monitor pops and
//               compares at the falling edge of that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtopl_lfo_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       zero = 1'b0;
    logic       am_dep = 1'b1;
    logic       lfo_rst = 1'b0;
    logic [2:0] vib_cnt;
    logic [4:0] trem;
    logic       vib_stb;
    logic       trem_stb;

    typedef struct {
        int cyc;
        int tag;
        int vib;
        int trm;
        int vs;
        int ts;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   vstb_cnt = 0;
    bit   vcount_en = 1'b0;

    jtopl_lfo_gen dut (
        .rst      (rst),
        .clk      (clk),
        .cen      (cen),
        .zero     (zero),
        .am_dep   (am_dep),
        .lfo_rst  (lfo_rst),
        .vib_cnt  (vib_cnt),
        .trem     (trem),
        .vib_stb  (vib_stb),
        .trem_stb (trem_stb)
    );

    always #5 clk = ~clk;

    // Cycle index used to time-stamp expectations.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            total++;
            if (int'(vib_cnt) != e.vib || int'(trem) != e.trm ||
                int'(vib_stb) != e.vs || int'(trem_stb) != e.ts) begin
                bad++;
                $display("FAIL chk%0d: got vib=%0d trem=%0d vstb=%0d tstb=%0d want vib=%0d trem=%0d vstb=%0d tstb=%0d",
                         e.tag, vib_cnt, trem, vib_stb, trem_stb, e.vib, e.trm, e.vs, e.ts);
            end
        end
        if (vcount_en && vib_stb) vstb_cnt++;
    end

    task automatic step(input logic c, input logic z);
        cen  = c;
        zero = z;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1, 1'b1);
    endtask

    task automatic idle();
        step(1'b1, 1'b0);
    endtask

    task automatic chk(input int tag, input int v, input int t, input int vs, input int ts);
        exp_t e;
        e.cyc = cyc;
        e.tag = tag;
        e.vib = v;
        e.trm = t;
        e.vs  = vs;
        e.ts  = ts;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        lfo_rst = 1'b0;
        am_dep  = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // Vibrato timing and wrap
        do_reset();
        chk(1, 0, 0, 0, 0);
        vcount_en = 1'b1;
        ticks(1023);
        chk(2, 0, 3, 0, 0);
        ticks(1);
        chk(3, 1, 3, 1, 1);
        idle();
        chk(4, 1, 4, 0, 0);
        vcount_en = 1'b0;
        total++;
        if (vstb_cnt != 1) begin
            bad++;
            $display("FAIL vstb_pulses: got %0d want 1", vstb_cnt);
        end
        ticks(7168);
        chk(5, 0, 20, 1, 1);

        // Tremolo triangle, deep/shallow depth, position wrap
        do_reset();
        ticks(64);
        chk(10, 0, 0, 0, 1);
        idle();
        chk(11, 0, 0, 0, 0);
        ticks(192);
        chk(12, 0, 0, 0, 1);
        idle();
        chk(13, 0, 1, 0, 0);
        ticks(6400);
        chk(14, 6, 25, 0, 1);
        idle();
        chk(15, 6, 26, 0, 0);
        ticks(64);
        chk(16, 6, 26, 0, 1);
        idle();
        chk(17, 6, 26, 0, 0);
        am_dep = 1'b0;
        idle();
        chk(18, 6, 6, 0, 0);
        am_dep = 1'b1;
        idle();
        chk(19, 6, 26, 0, 0);
        ticks(6656);
        chk(20, 5, 0, 0, 1);
        idle();
        chk(21, 5, 0, 0, 0);
        ticks(64);
        chk(22, 5, 0, 0, 1);
        idle();
        chk(23, 5, 0, 0, 0);
        ticks(256);
        idle();
        chk(24, 5, 1, 0, 0);

        // Continue to vib=5 / pos=150, then LFO reset
        ticks(49664);
        chk(30, 5, 15, 0, 1);
        lfo_rst = 1'b1;
        repeat (3) begin
            step(1'b1, 1'b1);
            chk(31, 0, 0, 0, 0);
        end
        lfo_rst = 1'b0;
        ticks(1023);
        chk(32, 0, 3, 0, 0);
        ticks(1);
        chk(33, 1, 3, 1, 1);

        // zero with cen low is ignored; strobes hold while cen is low
        do_reset();
        repeat (1024) begin
            step(1'b0, 1'b1);
            step(1'b1, 1'b1);
        end
        chk(40, 1, 3, 1, 1);
        step(1'b0, 1'b1);
        chk(41, 1, 3, 1, 1);
        idle();
        chk(42, 1, 4, 0, 0);

        // rst beats a tick at timer=1023
        do_reset();
        ticks(1023);
        chk(50, 0, 3, 0, 0);
        rst = 1'b1;
        step(1'b1, 1'b1);
        chk(51, 0, 0, 0, 0);
        rst = 1'b0;
        ticks(1);
        chk(52, 0, 0, 0, 0);
        ticks(62);
        chk(53, 0, 0, 0, 0);
        ticks(1);
        chk(54, 0, 0, 0, 1);

        idle();
        idle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
